axis_arbiter_mux: RTL
=====================

# axis_arbiter_mux

Packet-level N:1 AXI-Stream arbiter and multiplexer. It shares one downstream AXI-Stream sink between NUM_SRC upstream masters, such as several axis_master_bfm instances or DMA channels, and feeds one axis_if consumer. Arbitration is round-robin and happens only at packet boundaries. Once a source is granted, it owns the output until its tlast beat is accepted.

## Interface
Parameters:
- NUM_SRC, 4, number of upstream sources (2..16)
- DATA_WIDTH, 32, tdata width; multiple of 8
- ID_WIDTH, 4, tid width; must be ≥ $clog2(NUM_SRC) when AXIS_ARB_TID_EN is defined
- DEST_WIDTH, 1, tdest width
- USER_WIDTH, 1, tuser width

Ports (s_* buses are flattened, source i occupies slice i; KW = DATA_WIDTH/8):
- aclk  in  1  clock; everything is rising-edge
- aresetn  in  1  reset; asynchronous assert, active-low
- s_tvalid  in  NUM_SRC  per-source valid
- s_tready  out  NUM_SRC  per-source ready
- s_tdata  in  NUM_SRC*DATA_WIDTH  per-source data
- s_tstrb, s_tkeep  in  NUM_SRC*KW  per-source byte qualifiers
- s_tlast  in  NUM_SRC  per-source end-of-packet
- s_tid  in  NUM_SRC*ID_WIDTH  per-source id
- s_tdest  in  NUM_SRC*DEST_WIDTH  per-source destination
- s_tuser  in  NUM_SRC*USER_WIDTH  per-source user
- m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  matching single widths  downstream stream
- m_tready  in  1  downstream ready
- grant  out  NUM_SRC  one-hot current owner; zero when idle
- busy  out  1  high while a packet is in progress

## Operation
- FSM states:
  - IDLE: no owner.
    - m_tvalid=0, all s_tready=0, m_* payload=0.
    - If any s_tvalid is set, latch the winner into grant_q and go to BUSY.
  - BUSY: output is a combinational mux of the granted source.
    - m_tvalid = s_tvalid[g].
    - s_tready[g] = m_tready; all other s_tready = 0.
    - On the accepted beat (m_tvalid & m_tready & m_tlast): set last_q = g, go to IDLE.
- Round-robin order:
  - Search starts at last_q+1 and wraps modulo NUM_SRC.
  - The first source with s_tvalid set wins.
  - last_q resets to NUM_SRC-1, so source 0 has first priority after reset.
- The winner is evaluated only in IDLE. s_tvalid changes during BUSY do not affect ownership.
- The owner may deassert s_tvalid mid-packet. Ownership is held and m_tvalid follows it, so the bubble passes through.
- A packet is any run of beats ending in tlast. A single-beat packet (tlast on its first beat) releases after that beat.
- No internal storage of payload. The block is a pure mux plus control.
- busy equals (state == BUSY). grant equals the one-hot of grant_q while in BUSY, and 0 otherwise.

## Timing
- Reset values: state=IDLE, grant_q=0, last_q=NUM_SRC-1. This gives m_tvalid=0, s_tready=0, grant=0, busy=0, m_* payload=0.
- Arbitration latency is 1 cycle:
  - A request seen in IDLE at edge k makes the granted beat visible on m_* in cycle k+1.
  - The beat transfers at the first m_tready edge from then on.
- Data path latency is 0 cycles: m_* is combinational from the granted s_* in BUSY.
- Packet turnaround: after the tlast handshake there is exactly one IDLE cycle (m_tvalid=0) before the next packet.
- Simultaneous requests in IDLE: exactly one grant, chosen by RR order.
- If m_tready stays low, the owner stalls indefinitely. There is no timeout.
- Reset mid-packet: asynchronous return to IDLE; outputs drop to their reset values immediately, and the partial packet is abandoned.
- AXI rule: the block never deasserts m_tvalid on its own while BUSY and m_tvalid=1. m_tvalid only follows s_tvalid[g].

## Configuration
- AXIS_ARB_TID_EN defined: m_tid = grant index, zero-extended to ID_WIDTH, and s_tid is ignored. Elaboration error if ID_WIDTH < $clog2(NUM_SRC).
- AXIS_ARB_TID_EN undefined: m_tid = s_tid of the granted source, passed through.

## Structure
- The shared package axis_pkg holds:
  - the default width localparams (DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t.
- One sub-module, axis_rr_arb:
  - Inputs: req[NUM_SRC], last_q.
  - Outputs: one-hot gnt and its binary index.
  - Purely combinational rotate-priority-unrotate logic.
- axis_arbiter_mux holds the FSM, grant_q/last_q registers and the payload mux.

## Test plan
- Reset mid-packet: source 1 sends beat 2 of 4, then assert aresetn=0 → m_tvalid=0, grant=0 the same cycle. After release, source 0 has first priority.
- Single requester: source 2 sends a 3-beat packet (0xA0..0xA2), m_tready=1 → grant=4'b0100 from cycle k+1. Beats arrive in order and busy drops after the tlast beat.
- All four request at once with 2-beat packets → packets leave in order 0,1,2,3, with one idle cycle between packets. The 8 beats are complete by cycle 12.
- Backpressure: m_tready toggles 1010… during a 4-beat packet → no beat is lost or duplicated; s_tready[g] mirrors m_tready and the other s_tready stay 0.
- Late requester: source 3 asserts s_tvalid mid-packet from source 0 → ownership is unchanged; source 3 is granted after source 0's tlast plus one idle cycle.
- With AXIS_ARB_TID_EN: source 3 sends s_tid=0xF → m_tid=0x3. Without the macro → m_tid=0xF.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: default bus widths and the arbiter state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axis_pkg;

  // Default widths used when a block is instantiated without overrides.
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 4;
  localparam int DEST_WIDTH = 1;
  localparam int USER_WIDTH = 1;

  // Packet-level arbiter ownership state.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage : axis_pkg

// File: rtl/axis_rr_arb.sv
// Round-robin request picker: the search starts one past the previous winner and wraps.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when the pick is used.
//
// Ports:
//   req     - per-source request vector
//   last_q  - index of the previous winner (search starts at last_q+1)
//   gnt     - one-hot winner, all zero when no request is set
//   gnt_idx - binary index of the winner (zero when no request is set)
module axis_rr_arb #(
  parameter  int NUM_SRC = 4,
  localparam int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_q,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  import axis_pkg::*;

  logic [IDX_W-1:0]   start;
  logic [NUM_SRC-1:0] rot;
  logic [IDX_W-1:0]   rot_idx;
  logic [IDX_W:0]     sum;
  logic               found;

  always_comb begin
    // First source searched; wraps back to 0 after the top index.
    start = (last_q == IDX_W'(NUM_SRC - 1)) ? '0 : last_q + IDX_W'(1);

    // Rotate so bit 0 of rot corresponds to the highest-priority source.
    rot = NUM_SRC'({req, req} >> start);

    // Fixed priority on the rotated vector: lowest set bit wins.
    rot_idx = '0;
    found   = 1'b0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (rot[j]) begin
        rot_idx = IDX_W'(j);
        found   = 1'b1;
      end
    end

    // Undo the rotation, modulo NUM_SRC (NUM_SRC need not be a power of two).
    sum = {1'b0, start} + {1'b0, rot_idx};
    if (sum >= (IDX_W + 1)'(NUM_SRC)) begin
      sum = sum - (IDX_W + 1)'(NUM_SRC);
    end

    gnt_idx = found ? sum[IDX_W-1:0] : '0;
    gnt     = found ? (NUM_SRC'(1) << sum[IDX_W-1:0]) : '0;
  end

endmodule : axis_rr_arb

// File: rtl/axis_arbiter_mux.sv
// Packet-level N:1 AXI-Stream round-robin arbiter and mux; the owner holds the output until its tlast beat.
// Latency: 1 cycle request-to-grant, 0 cycles on the data path (m_* is a mux of the granted s_*).
// Backpressure: m_tready is routed to the owner's s_tready only; all other sources see s_tready=0.
//
// Ports:
//   aclk, aresetn          - clock (rising edge) and asynchronous active-low reset
//   s_t*                   - NUM_SRC flattened upstream streams, source i in slice i
//   m_t*                   - single downstream stream
//   grant                  - one-hot current owner, zero when idle
//   busy                   - high while a packet is in progress
// Build option: define AXIS_ARB_TID_EN to drive m_tid with the owner index instead of passing s_tid.
module axis_arbiter_mux #(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = axis_pkg::DATA_WIDTH,
  parameter  int ID_WIDTH   = axis_pkg::ID_WIDTH,
  parameter  int DEST_WIDTH = axis_pkg::DEST_WIDTH,
  parameter  int USER_WIDTH = axis_pkg::USER_WIDTH,
  localparam int KW         = DATA_WIDTH / 8
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  // upstream sources
  input  logic [NUM_SRC-1:0]               s_tvalid,
  output logic [NUM_SRC-1:0]               s_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_tdata,
  input  logic [NUM_SRC*KW-1:0]            s_tstrb,
  input  logic [NUM_SRC*KW-1:0]            s_tkeep,
  input  logic [NUM_SRC-1:0]               s_tlast,
  input  logic [NUM_SRC*ID_WIDTH-1:0]      s_tid,
  input  logic [NUM_SRC*DEST_WIDTH-1:0]    s_tdest,
  input  logic [NUM_SRC*USER_WIDTH-1:0]    s_tuser,
  // downstream sink
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic [KW-1:0]                    m_tstrb,
  output logic [KW-1:0]                    m_tkeep,
  output logic                             m_tlast,
  output logic [ID_WIDTH-1:0]              m_tid,
  output logic [DEST_WIDTH-1:0]            m_tdest,
  output logic [USER_WIDTH-1:0]            m_tuser,
  // status
  output logic [NUM_SRC-1:0]               grant,
  output logic                             busy
);

  import axis_pkg::*;

  localparam int IDX_W = $clog2(NUM_SRC);

  // Elaboration-time parameter sanity checks.
  if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
    $error("axis_arbiter_mux: NUM_SRC must be in 2..16");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
    $error("axis_arbiter_mux: DATA_WIDTH must be a non-zero multiple of 8");
  end
`ifdef AXIS_ARB_TID_EN
  if (ID_WIDTH < $clog2(NUM_SRC)) begin : g_bad_id_width
    $error("axis_arbiter_mux: ID_WIDTH too narrow to carry the source index");
  end
`endif

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   last_q;
  logic               load_grant;
  logic               release_pkt;

  logic [NUM_SRC-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;

  // Fields of the currently granted source.
  logic [NUM_SRC-1:0]    sel_onehot;
  logic                  sel_vld;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KW-1:0]         sel_strb;
  logic [KW-1:0]         sel_keep;
  logic                  sel_last;
  logic [DEST_WIDTH-1:0] sel_dest;
  logic [USER_WIDTH-1:0] sel_user;
`ifndef AXIS_ARB_TID_EN
  logic [ID_WIDTH-1:0]   sel_tid;
`else
  // s_tid is intentionally ignored when the owner index drives m_tid.
  logic unused_tid;
  assign unused_tid = ^s_tid;
`endif

  axis_rr_arb #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_arb (
    .req     (s_tvalid),
    .last_q  (last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Payload select by registered owner index.
  always_comb begin
    sel_onehot = '0;
    sel_vld    = 1'b0;
    sel_data   = '0;
    sel_strb   = '0;
    sel_keep   = '0;
    sel_last   = 1'b0;
    sel_dest   = '0;
    sel_user   = '0;
`ifndef AXIS_ARB_TID_EN
    sel_tid    = '0;
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_vld       = s_tvalid[i];
        sel_data      = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb      = s_tstrb[i*KW +: KW];
        sel_keep      = s_tkeep[i*KW +: KW];
        sel_last      = s_tlast[i];
        sel_dest      = s_tdest[i*DEST_WIDTH +: DEST_WIDTH];
        sel_user      = s_tuser[i*USER_WIDTH +: USER_WIDTH];
`ifndef AXIS_ARB_TID_EN
        sel_tid       = s_tid[i*ID_WIDTH +: ID_WIDTH];
`endif
      end
    end
  end

  // Next state and outputs. Everything is forced to zero in IDLE so an
  // idle arbiter never exposes a stale payload downstream.
  always_comb begin
    state_d     = state_q;
    load_grant  = 1'b0;
    release_pkt = 1'b0;
    m_tvalid    = 1'b0;
    m_tdata     = '0;
    m_tstrb     = '0;
    m_tkeep     = '0;
    m_tlast     = 1'b0;
    m_tid       = '0;
    m_tdest     = '0;
    m_tuser     = '0;
    s_tready    = '0;
    grant       = '0;
    busy        = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (|arb_gnt) begin
          load_grant = 1'b1;
          state_d    = ARB_BUSY;
        end
      end

      ARB_BUSY: begin
        busy     = 1'b1;
        grant    = sel_onehot;
        // m_tvalid only ever follows the owner; a bubble from the owner passes straight through.
        m_tvalid = sel_vld;
        m_tdata  = sel_data;
        m_tstrb  = sel_strb;
        m_tkeep  = sel_keep;
        m_tlast  = sel_last;
        m_tdest  = sel_dest;
        m_tuser  = sel_user;
`ifdef AXIS_ARB_TID_EN
        m_tid    = ID_WIDTH'(grant_q);
`else
        m_tid    = sel_tid;
`endif
        s_tready = sel_onehot & {NUM_SRC{m_tready}};
        if (sel_vld && m_tready && sel_last) begin
          release_pkt = 1'b1;
          state_d     = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // last_q starts at the top index so source 0 is searched first after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      if (load_grant) begin
        grant_q <= arb_idx;
      end
      if (release_pkt) begin
        last_q <= grant_q;
      end
    end
  end

endmodule : axis_arbiter_mux
